// File: rtl/strided_buf_sched.sv
// Write/read scheduler for a column-strided line buffer: streams input columns into the buffer
// and issues {ox, y, cw} read commands once K columns of the current window have settled.
module strided_buf_sched #(
    parameter int N_BUF_X    = 5,
    parameter int K          = 3,
    parameter int B_DSHAPE   = 48,
    parameter int B_COORD    = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [B_DSHAPE-1:0]   dshape,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  buf_clr,
    output logic                  buf_en,
    output logic [DATA_WIDTH-1:0] buf_di,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [3*B_COORD-1:0]  m_coord,
    output logic [2:0]            m_slot,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = B_COORD + 1;
    localparam logic [15:0] COORD_MAX = 16'((1 << B_COORD) - 1);
    localparam logic [15:0] K16       = 16'(K);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t state, state_nx;
    logic   aborting;

    logic [15:0] in_w, in_h, in_c;
    logic [9:0]  in_n_cw;
    logic        shape_ok;

    logic [CW-1:0] w_q, h_q, ox_last_q;
    logic [9:0]    n_cw_q;
    logic [15:0]   col_words_q;

    logic [15:0]   word_cnt;
    logic [CW-1:0] cols_wr, cols_rel, avail_d1, avail_d2, cols_avail;
    logic [B_COORD-1:0] ox, y;
    logic [9:0]    cw;
    logic [2:0]    slot;

    logic          s_fire, m_fire, cw_last, y_last, ox_last;
    logic [CW-1:0] need_cols, occupancy;

    assign in_w    = dshape[47:32];
    assign in_h    = dshape[31:16];
    assign in_c    = dshape[15:0];
    assign in_n_cw = in_c[15:6];
    assign shape_ok = (in_n_cw != '0) && (in_h != '0) && (in_h <= COORD_MAX) &&
                      (in_w >= K16) && (in_w <= COORD_MAX);

    assign cw_last   = (cw == n_cw_q - 10'd1);
    assign y_last    = ({1'b0, y} == h_q - CW'(1));
    assign ox_last   = ({1'b0, ox} == ox_last_q);
    assign need_cols = {1'b0, ox} + CW'(K);
    assign occupancy = cols_wr - cols_rel;

    // abort masks both handshakes so nothing is written or issued in the cycle it is seen
    assign s_ready = (state == RUN) && !abort && (cols_wr < w_q) && (occupancy < CW'(N_BUF_X));
    assign m_valid = (state == RUN) && !abort && (cols_avail >= need_cols);
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;
    assign m_coord = {ox, y, B_COORD'(cw)};
    assign m_slot  = slot;
    assign m_last  = m_valid && ox_last && y_last && cw_last;
    assign busy    = (state != IDLE);
    assign buf_clr = (state == CLEAR);
    assign done    = (state == DONE) && !abort;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && shape_ok) state_nx = CLEAR;
            CLEAR:   state_nx = (aborting || abort) ? IDLE : RUN;
            RUN: begin
                if (abort)                 state_nx = CLEAR;
                else if (m_fire && m_last) state_nx = DONE;
            end
            DONE:    state_nx = abort ? CLEAR : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            aborting <= 1'b0;
            err      <= 1'b0;
            buf_en   <= 1'b0;
            buf_di   <= '0;
        end else begin
            state    <= state_nx;
            aborting <= abort && ((state == RUN) || (state == DONE));
            err      <= (state == IDLE) && start && !shape_ok;
            buf_en   <= s_fire;
            if (s_fire) buf_di <= s_data;
        end
    end

    // NOTE: these are plain flops, not a memory array, so resetting all of them is cheap and keeps
    // the first job after reset identical to one after power-up.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_q         <= '0;
            h_q         <= '0;
            ox_last_q   <= '0;
            n_cw_q      <= '0;
            col_words_q <= '0;
        end else if ((state == IDLE) && start && shape_ok) begin
            w_q         <= in_w[CW-1:0];
            h_q         <= in_h[CW-1:0];
            ox_last_q   <= in_w[CW-1:0] - CW'(K);
            n_cw_q      <= in_n_cw;
            col_words_q <= {6'd0, in_n_cw} * in_h;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt   <= '0;
            cols_wr    <= '0;
            cols_rel   <= '0;
            avail_d1   <= '0;
            avail_d2   <= '0;
            cols_avail <= '0;
            ox         <= '0;
            y          <= '0;
            cw         <= '0;
            slot       <= '0;
        end else if (state == CLEAR) begin
            word_cnt   <= '0;
            cols_wr    <= '0;
            cols_rel   <= '0;
            avail_d1   <= '0;
            avail_d2   <= '0;
            cols_avail <= '0;
            ox         <= '0;
            y          <= '0;
            cw         <= '0;
            slot       <= '0;
        end else begin
            // Three-stage delay matches the buffer's internal write pipeline.
            avail_d1   <= cols_wr;
            avail_d2   <= avail_d1;
            cols_avail <= avail_d2;

            if (s_fire) begin
                if (word_cnt == col_words_q - 16'd1) begin
                    word_cnt <= '0;
                    cols_wr  <= cols_wr + CW'(1);
                end else begin
                    word_cnt <= word_cnt + 16'd1;
                end
            end

            if (m_fire) begin
                if (cw_last) begin
                    cw <= '0;
                    if (y_last) begin
                        y        <= '0;
                        ox       <= ox + B_COORD'(1);
                        slot     <= (slot == 3'(N_BUF_X - 1)) ? 3'd0 : slot + 3'd1;
                        cols_rel <= cols_rel + CW'(1);
                    end else begin
                        y <= y + B_COORD'(1);
                    end
                end else begin
                    cw <= cw + 10'd1;
                end
            end
        end
    end

endmodule
